// File: rtl/shifter_pipe_pkg.sv
// rtl/shifter_pipe_pkg.sv - shared ALU constants and shift op encodings
package shifter_pipe_pkg;

    localparam int ALU_OP_W = 2;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t OP_SLL  = 2'b00;
    localparam alu_op_t OP_SRL  = 2'b01;
    localparam alu_op_t OP_SRA  = 2'b10;
    localparam alu_op_t OP_ROTR = 2'b11;

endpackage

// File: rtl/shifter_pipe_shift_stage.sv
// rtl/shifter_pipe_shift_stage.sv - partial shift by amt * 2**LO_BIT, purely combinational
module shift_stage
    import shifter_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int LO_BIT = 0,
    parameter int NBITS  = 2
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic [NBITS-1:0] amt,
    output logic [WIDTH-1:0] dout
);

    localparam int SW = LO_BIT + NBITS;

    logic [SW-1:0]        sh;
    logic [2*WIDTH-1:0]   rot;

    // Only 2**NBITS distinct shift distances reach this stage.
    assign sh  = SW'(amt) << LO_BIT;
    assign rot = {din, din} >> sh;

    always_comb begin
        dout = din;
        case (op)
            OP_SLL:  dout = din << sh;
            OP_SRL:  dout = din >> sh;
            OP_SRA:  dout = $signed(din) >>> sh;
            OP_ROTR: dout = rot[WIDTH-1:0];
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - two-stage valid/ready barrel shifter (SLL, SRL, SRA, ROTR)
module shifter_pipe
    import shifter_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res
);

    localparam int SAW = $clog2(WIDTH);
    localparam int LOW = SAW / 2;
    localparam int HIW = SAW - LOW;

    logic             v1, v2;
    logic [WIDTH-1:0] d1, d2;
    logic [1:0]       op1;
    logic [LOW-1:0]   lo1;
    logic [WIDTH-1:0] s1_out, s2_out;
    logic             adv1, adv2, accept;
    logic             unused_b;

    assign unused_b = ^B[WIDTH-1:SAW];

    assign adv2     = ~v2 | out_ready;
    assign adv1     = ~v1 | adv2;
    // rst_n gates in_ready so nothing is offered as accepted while held in reset.
    assign in_ready = adv1 & ~flush & rst_n;
    assign accept   = in_valid & in_ready;

    assign out_valid = v2;
    assign res       = v2 ? d2 : '0;

    shift_stage #(.WIDTH(WIDTH), .LO_BIT(LOW), .NBITS(HIW)) u_stage1 (
        .op   (op),
        .din  (A),
        .amt  (B[SAW-1:LOW]),
        .dout (s1_out)
    );

    shift_stage #(.WIDTH(WIDTH), .LO_BIT(0), .NBITS(LOW)) u_stage2 (
        .op   (op1),
        .din  (d1),
        .amt  (lo1),
        .dout (s2_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            d1  <= '0;
            d2  <= '0;
            op1 <= '0;
            lo1 <= '0;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    d2 <= s2_out;
                end
            end
            if (adv1) begin
                v1 <= accept;
                if (accept) begin
                    d1  <= s1_out;
                    op1 <= op;
                    lo1 <= B[LOW-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_shifter_pipe.sv
// tb/tb_shifter_pipe.sv - randomized and directed checks of shifter_pipe against a bitwise model
module tb_shifter_pipe;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [W-1:0]  A, B;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  res;

    int            errors = 0;
    int            checks = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  cur_exp;
    logic [W-1:0]  held_res;
    bit            stall_prev = 0;

    shifter_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bit i of the result is picked from A by index arithmetic on the shift amount.
    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W-1:0] r;
        int sa;
        sa = int'(b % W);
        for (int i = 0; i < W; i++) begin
            case (o)
                2'd0:    r[i] = (i >= sa) ? a[i-sa] : 1'b0;
                2'd1:    r[i] = (i + sa < W) ? a[i+sa] : 1'b0;
                2'd2:    r[i] = (i + sa < W) ? a[i+sa] : a[W-1];
                default: r[i] = a[(i+sa)%W];
            endcase
        end
        return r;
    endfunction

    task automatic cycle(output bit acc);
        #1;
        acc = in_valid && in_ready;
        if (stall_prev) begin
            check("hold_valid", {31'b0, out_valid}, 1);
            check("hold_res", res, held_res);
        end
        if (!out_valid) check("idle_res", res, 0);
        if (acc) exp_q.push_back(cur_exp);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_result", {31'b0, out_valid}, 0);
            else check("res", res, exp_q.pop_front());
        end
        stall_prev = out_valid && !out_ready && !flush;
        held_res   = res;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e);
        bit acc;
        int n;
        n = 0;
        in_valid = 1; op = o; A = a; B = b; cur_exp = e;
        do begin
            cycle(acc);
            n++;
        end while (!acc && n < 50);
        if (!acc) check("send_timeout", {31'b0, acc}, 1);
        in_valid = 0;
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        in_valid = 0; out_ready = 1;
        while (exp_q.size() != 0 && n < 20) begin
            cycle(acc);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit acc;
        rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
        op = 0; A = 0; B = 0; cur_exp = 0;

        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_res", res, 0);
        check("rst_in_ready", {31'b0, in_ready}, 0);
        rst_n = 1;

        // Latency with no backpressure
        out_ready = 1;
        send(2'd0, 32'h1, 32'd31, 32'h80000000);
        check("lat_edge1_valid", {31'b0, out_valid}, 0);
        cycle(acc);
        check("lat_edge2_valid", {31'b0, out_valid}, 1);
        check("lat_edge2_res", res, 32'h80000000);
        drain();

        send(2'd0, 32'h1, 32'h21, 32'h2);
        send(2'd2, 32'h80000000, 32'd4, 32'hF8000000);
        send(2'd1, 32'h80000000, 32'd4, 32'h08000000);
        send(2'd3, 32'h1, 32'd1, 32'h80000000);
        for (int o = 0; o < 4; o++) send(2'(o), 32'h1, 32'h20, 32'h1);
        send(2'd3, 32'h12345678, 32'd8, 32'h78123456);
        drain();

        // Backpressure: out_ready low for three cycles while inputs stream in
        out_ready = 0;
        in_valid = 1; op = 2'd0; A = 32'h3; B = 32'd1; cur_exp = 32'h6;
        cycle(acc);
        check("bp_acc0", {31'b0, acc}, 1);
        op = 2'd1; A = 32'hF0; B = 32'd4; cur_exp = 32'hF;
        cycle(acc);
        check("bp_acc1", {31'b0, acc}, 1);
        op = 2'd2; A = 32'h80000010; B = 32'd1; cur_exp = 32'hC0000008;
        cycle(acc);
        check("bp_in_ready_low", {31'b0, acc}, 0);
        out_ready = 1;
        send(2'd2, 32'h80000010, 32'd1, 32'hC0000008);
        send(2'd3, 32'h0000000F, 32'd4, 32'hF0000000);
        drain();

        // Flush with both stages full: nothing stale may appear afterwards
        out_ready = 0;
        send(2'd0, 32'hAAAA, 32'd3, 32'h55550);
        send(2'd0, 32'hBBBB, 32'd2, 32'h2EEEC);
        in_valid = 1; op = 2'd0; A = 32'hCC; B = 32'd0; cur_exp = 32'hCC;
        flush = 1;
        cycle(acc);
        check("flush_no_accept", {31'b0, acc}, 0);
        check("flush_out_valid", {31'b0, out_valid}, 0);
        flush = 0; in_valid = 0;
        exp_q.delete();
        out_ready = 1;
        for (int i = 0; i < 4; i++) cycle(acc);

        // Asynchronous reset mid-stream
        send(2'd1, 32'hFFFF0000, 32'd16, 32'h0000FFFF);
        send(2'd1, 32'hFFFF0000, 32'd8, 32'h00FFFF00);
        #2;
        rst_n = 0;
        #1;
        check("async_rst_out_valid", {31'b0, out_valid}, 0);
        check("async_rst_res", res, 0);
        check("async_rst_in_ready", {31'b0, in_ready}, 0);
        exp_q.delete();
        stall_prev = 0;
        @(negedge clk);
        rst_n = 1;
        send(2'd0, 32'h5, 32'd2, 32'h14);
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op = 2'($urandom_range(0, 3));
            A  = $urandom;
            B  = $urandom;
            cur_exp = model(op, A, B);
            cycle(acc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
